// File: rtl/pooling_pkg.sv
// Shared definitions for the pooling layer: controller state encoding and
// the default layer geometry used by both the controller and the datapath.
package pooling_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } pool_ctrl_state_t;

    // Default layer geometry; pooling_layer_top uses the same values.
    localparam int DEF_FEATURE_NUM = 6;
    localparam int DEF_ROW_NUM     = 6;
    localparam int DEF_RD_LAT      = 1;

    // Width of a counter that must hold 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pooling_layer_ctrl_if.sv
// Control/handshake bundle between the layer scheduler, the feature buffer
// and the pooling datapath. master = the sequencer, slave = its environment.
interface pooling_layer_ctrl_if #(
    parameter int FEATURE_WIDTH = 3,
    parameter int ROW_WIDTH     = 3,
    parameter int ADDR_WIDTH    = 6
);
    logic                     start;
    logic                     abort;
    logic                     ds_ready;
    logic                     rd_en;
    logic [ADDR_WIDTH-1:0]    rd_addr;
    logic                     input_valid;
    logic [FEATURE_WIDTH-1:0] feature_idx;
    logic [ROW_WIDTH-1:0]     feature_row;
    logic                     busy;
    logic                     done;

    modport master (
        input  start, abort, ds_ready,
        output rd_en, rd_addr, input_valid, feature_idx, feature_row, busy, done
    );

    modport slave (
        output start, abort, ds_ready,
        input  rd_en, rd_addr, input_valid, feature_idx, feature_row, busy, done
    );
endinterface

// File: rtl/pool_align_pipe.sv
// Delay line that carries {valid, feature, row} alongside the buffer read
// latency so tags line up with the returned row data. Tag fields only load
// when a valid entry moves in, so the output tags hold between valid rows.
module pool_align_pipe #(
    parameter int STAGES        = 1,
    parameter int FEATURE_WIDTH = 3,
    parameter int ROW_WIDTH     = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     vld_in,
    input  logic [FEATURE_WIDTH-1:0] feat_in,
    input  logic [ROW_WIDTH-1:0]     row_in,
    output logic                     vld_out,
    output logic [FEATURE_WIDTH-1:0] feat_out,
    output logic [ROW_WIDTH-1:0]     row_out
);

    logic                     vld_p  [STAGES];
    logic [FEATURE_WIDTH-1:0] feat_p [STAGES];
    logic [ROW_WIDTH-1:0]     row_p  [STAGES];

    // Shift the tag pipeline; flush kills every in-flight entry and freezes tags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                vld_p[i]  <= 1'b0;
                feat_p[i] <= '0;
                row_p[i]  <= '0;
            end
        end else begin
            vld_p[0] <= vld_in & ~flush;
            if (vld_in && !flush) begin
                feat_p[0] <= feat_in;
                row_p[0]  <= row_in;
            end
            for (int i = 1; i < STAGES; i++) begin
                vld_p[i] <= vld_p[i-1] & ~flush;
                if (vld_p[i-1] && !flush) begin
                    feat_p[i] <= feat_p[i-1];
                    row_p[i]  <= row_p[i-1];
                end
            end
        end
    end

    assign vld_out  = vld_p[STAGES-1];
    assign feat_out = feat_p[STAGES-1];
    assign row_out  = row_p[STAGES-1];

endmodule

// File: rtl/pooling_layer_ctrl.sv
// Sequencer for the pooling datapath: walks every row of every feature map,
// issuing one buffer read per row while downstream is ready, and tags the
// returned rows with their feature/row indices after the read latency.
module pooling_layer_ctrl
    import pooling_pkg::*;
#(
    parameter int FEATURE_NUM   = DEF_FEATURE_NUM,
    parameter int FEATURE_WIDTH = 3,
    parameter int ROW_NUM       = DEF_ROW_NUM,
    parameter int ROW_WIDTH     = 3,
    parameter int ADDR_WIDTH    = 6,
    parameter int RD_LAT        = DEF_RD_LAT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pooling_layer_ctrl_if.master bus
);

    localparam int DRAIN_W = cnt_width(RD_LAT);

    localparam logic [FEATURE_WIDTH-1:0] FEAT_LAST  = FEATURE_WIDTH'(FEATURE_NUM - 1);
    localparam logic [ROW_WIDTH-1:0]     ROW_LAST   = ROW_WIDTH'(ROW_NUM - 1);
    localparam logic [ADDR_WIDTH-1:0]    ROW_NUM_A  = ADDR_WIDTH'(ROW_NUM);
    localparam logic [DRAIN_W-1:0]       DRAIN_LAST = DRAIN_W'(RD_LAT - 1);

    pool_ctrl_state_t state, state_nxt;

    logic [FEATURE_WIDTH-1:0] feat;
    logic [ROW_WIDTH-1:0]     row;
    logic [DRAIN_W-1:0]       drain_cnt;
    logic                     rd_fire;
    logic                     last_rd;
    logic                     pass_start;
    logic                     abort_act;
    logic [ADDR_WIDTH-1:0]    rd_addr_calc;

    // A read goes out only in RUN with downstream ready; abort suppresses it.
    assign rd_fire      = (state == ST_RUN) && bus.ds_ready && !bus.abort;
    assign last_rd      = rd_fire && (feat == FEAT_LAST) && (row == ROW_LAST);
    assign pass_start   = (state == ST_IDLE) && bus.start && !bus.abort;
    assign abort_act    = bus.abort && ((state == ST_RUN) || (state == ST_DRAIN));
    assign rd_addr_calc = ADDR_WIDTH'(feat) * ROW_NUM_A + ADDR_WIDTH'(row);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus the read strobe/address, which follow ds_ready directly
    always_comb begin
        state_nxt   = state;
        bus.rd_en   = 1'b0;
        bus.rd_addr = '0;
        unique case (state)
            ST_IDLE: begin
                if (pass_start) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (bus.abort)    state_nxt = ST_IDLE;
                else if (last_rd) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (bus.abort)                    state_nxt = ST_IDLE;
                else if (drain_cnt == DRAIN_LAST) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        if (rd_fire) begin
            bus.rd_en   = 1'b1;
            bus.rd_addr = rd_addr_calc;
        end
    end

    // Row/feature walk: advance after each issued read, restart on a new pass
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            feat <= '0;
            row  <= '0;
        end else if (pass_start || last_rd) begin
            feat <= '0;
            row  <= '0;
        end else if (rd_fire) begin
            if (row == ROW_LAST) begin
                row  <= '0;
                feat <= feat + 1'b1;
            end else begin
                row  <= row + 1'b1;
            end
        end
    end

    // DRAIN cycle counter: waits out the read latency of the final read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_cnt <= '0;
        end else if (state == ST_DRAIN) begin
            drain_cnt <= drain_cnt + 1'b1;
        end else begin
            drain_cnt <= '0;
        end
    end

    assign bus.busy = (state != ST_IDLE);
    assign bus.done = (state == ST_DONE);

    pool_align_pipe #(
        .STAGES        (RD_LAT),
        .FEATURE_WIDTH (FEATURE_WIDTH),
        .ROW_WIDTH     (ROW_WIDTH)
    ) u_align (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (abort_act),
        .vld_in   (rd_fire),
        .feat_in  (feat),
        .row_in   (row),
        .vld_out  (bus.input_valid),
        .feat_out (bus.feature_idx),
        .row_out  (bus.feature_row)
    );

endmodule

// File: tb/tb_pooling_layer_ctrl.sv
// Directed bench for pooling_layer_ctrl: default geometry with RD_LAT=1 and a
// second instance with RD_LAT=3. Cycle 0 is the cycle in which start is high.
module tb_pooling_layer_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic sel3  = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pooling_layer_ctrl_if #(.FEATURE_WIDTH(3), .ROW_WIDTH(3), .ADDR_WIDTH(6)) bus ();
    pooling_layer_ctrl_if #(.FEATURE_WIDTH(3), .ROW_WIDTH(3), .ADDR_WIDTH(6)) bus3 ();

    pooling_layer_ctrl #(
        .FEATURE_NUM(6), .FEATURE_WIDTH(3), .ROW_NUM(6), .ROW_WIDTH(3),
        .ADDR_WIDTH(6), .RD_LAT(1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    pooling_layer_ctrl #(
        .FEATURE_NUM(6), .FEATURE_WIDTH(3), .ROW_NUM(6), .ROW_WIDTH(3),
        .ADDR_WIDTH(6), .RD_LAT(3)
    ) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string t, input int c,
                              input logic o_rd, input int o_addr, input logic o_iv,
                              input int o_fi, input int o_fr, input logic o_bsy, input logic o_dn,
                              input logic e_rd, input int e_addr, input logic e_iv,
                              input int e_fi, input int e_fr, input logic e_bsy, input logic e_dn);
        string p;
        p = $sformatf("%s@%0d", t, c);
        check_eq({p, ".rd_en"},       32'(o_rd),  32'(e_rd));
        check_eq({p, ".rd_addr"},     o_addr,     e_addr);
        check_eq({p, ".input_valid"}, 32'(o_iv),  32'(e_iv));
        check_eq({p, ".feature_idx"}, o_fi,       e_fi);
        check_eq({p, ".feature_row"}, o_fr,       e_fr);
        check_eq({p, ".busy"},        32'(o_bsy), 32'(e_bsy));
        check_eq({p, ".done"},        32'(o_dn),  32'(e_dn));
    endtask

    task automatic chk1(input string t, input int c, input logic e_rd, input int e_addr,
                        input logic e_iv, input int e_fi, input int e_fr,
                        input logic e_bsy, input logic e_dn);
        check_outs(t, c, bus.rd_en, int'(bus.rd_addr), bus.input_valid,
                   int'(bus.feature_idx), int'(bus.feature_row), bus.busy, bus.done,
                   e_rd, e_addr, e_iv, e_fi, e_fr, e_bsy, e_dn);
    endtask

    task automatic chk3(input string t, input int c, input logic e_rd, input int e_addr,
                        input logic e_iv, input int e_fi, input int e_fr,
                        input logic e_bsy, input logic e_dn);
        check_outs(t, c, bus3.rd_en, int'(bus3.rd_addr), bus3.input_valid,
                   int'(bus3.feature_idx), int'(bus3.feature_row), bus3.busy, bus3.done,
                   e_rd, e_addr, e_iv, e_fi, e_fr, e_bsy, e_dn);
    endtask

    // Advance to the next cycle, drive its inputs, then settle before sampling.
    task automatic step(input logic s, input logic a, input logic r);
        @(posedge clk);
        #1;
        bus.start     = s & ~sel3;
        bus3.start    = s & sel3;
        bus.abort     = a;
        bus3.abort    = a;
        bus.ds_ready  = r;
        bus3.ds_ready = r;
        #1;
    endtask

    // Uninterrupted pass on the RD_LAT=1 instance; optional stray start at extra_start.
    task automatic full_pass(input string t, input int extra_start, input int init_fi, input int init_fr);
        int   efi;
        int   efr;
        logic rd;
        logic iv;
        efi = init_fi;
        efr = init_fr;
        for (int c = 0; c <= 40; c++) begin
            step(c == 0 || c == extra_start, 1'b0, 1'b1);
            rd = (c >= 1 && c <= 36);
            iv = (c >= 2 && c <= 37);
            if (iv) begin
                efi = (c - 2) / 6;
                efr = (c - 2) % 6;
            end
            chk1(t, c, rd, rd ? c - 1 : 0, iv, efi, efr, (c >= 1 && c <= 38), (c == 38));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int   efi;
        int   efr;
        int   k;
        logic rd;
        logic iv;

        bus.start = 1'b0;  bus.abort = 1'b0;  bus.ds_ready = 1'b0;
        bus3.start = 1'b0; bus3.abort = 1'b0; bus3.ds_ready = 1'b0;

        // Reset state on both instances.
        repeat (2) @(posedge clk);
        #2;
        chk1("reset", 0, 1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
        chk3("reset3", 0, 1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // start and abort together in IDLE: stays idle.
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk1("start_abort_idle", 1, 1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);

        // Clean full pass.
        full_pass("pass", -1, 0, 0);

        // Stray start mid-pass is ignored.
        full_pass("start20", 20, 5, 5);

        // ds_ready low in cycles 5..7.
        efi = 5;
        efr = 5;
        for (int c = 0; c <= 44; c++) begin
            step(c == 0, 1'b0, !(c >= 5 && c <= 7));
            rd = (c >= 1 && c <= 4) || (c >= 8 && c <= 39);
            iv = (c >= 2 && c <= 5) || (c >= 9 && c <= 40);
            if (iv) begin
                k   = (c <= 5) ? c - 2 : c - 5;
                efi = k / 6;
                efr = k % 6;
            end
            chk1("stall", c, rd, rd ? ((c <= 4) ? c - 1 : c - 4) : 0, iv, efi, efr,
                 (c >= 1 && c <= 41), (c == 41));
        end

        // abort in cycle 10.
        efi = 5;
        efr = 5;
        for (int c = 0; c <= 14; c++) begin
            step(c == 0, c == 10, 1'b1);
            rd = (c >= 1 && c <= 9);
            iv = (c >= 2 && c <= 10);
            if (iv) begin
                efi = (c - 2) / 6;
                efr = (c - 2) % 6;
            end
            chk1("abort", c, rd, rd ? c - 1 : 0, iv, efi, efr, (c >= 1 && c <= 10), 1'b0);
        end

        // Reset asserted in cycle 15 of a pass.
        efi = 1;
        efr = 2;
        for (int c = 0; c <= 14; c++) begin
            step(c == 0, 1'b0, 1'b1);
            rd = (c >= 1);
            iv = (c >= 2);
            if (iv) begin
                efi = (c - 2) / 6;
                efr = (c - 2) % 6;
            end
            chk1("pre_rst", c, rd, rd ? c - 1 : 0, iv, efi, efr, (c >= 1), 1'b0);
        end
        step(1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("mid_rst", 15, 1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;
        #1;
        chk1("post_rst", 16, 1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk1("post_rst", 17, 1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
        full_pass("after_rst", -1, 0, 0);

        // RD_LAT = 3 instance.
        sel3 = 1'b1;
        efi  = 0;
        efr  = 0;
        for (int c = 0; c <= 43; c++) begin
            step(c == 0, 1'b0, 1'b1);
            rd = (c >= 1 && c <= 36);
            iv = (c >= 4 && c <= 39);
            if (iv) begin
                efi = (c - 4) / 6;
                efr = (c - 4) % 6;
            end
            chk3("lat3", c, rd, rd ? c - 1 : 0, iv, efi, efr, (c >= 1 && c <= 40), (c == 40));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
